// File: rtl/ip_chksum.sv
// Ones-complement checksum engine for the DM9000A header builder: reads a byte run
// from the shared dpram, sums it as big-endian 16-bit words and folds the carries.
module ip_chksum (
    input  logic        iDm9000aClk,
    input  logic        iRst_n,
    input  logic        iRunStart,
    input  logic [15:0] in_len,
    input  logic [9:0]  in_start_addr,
    output logic [9:0]  oAddress,
    input  logic [7:0]  iQ,
    output logic [15:0] oChecksum,
    output logic        oRunEnd
);

    typedef enum logic [2:0] {IDLE, LATCH, READ, DRAIN, FOLD1, FOLD2, DONE} state_t;

    state_t      state_q;
    logic [15:0] len_q;
    logic [9:0]  start_q;
    logic [15:0] idx_q;
    logic [31:0] acc_q;
    logic [7:0]  hi_q;
    logic        rdValid_q;
    logic        rdOdd_q;
    logic [9:0]  addr_q;
    logic [15:0] chk_q;
    logic        runEnd_q;

    logic [31:0] acc_d;
    logic [7:0]  hi_d;
    logic [31:0] fold_d;
    logic [15:0] idxNext;
    logic [9:0]  addrNext;

    // Read data arrives one cycle after its address; even offsets park in hi_q,
    // odd offsets complete a word. A trailing even byte in DRAIN is zero-padded.
    always_comb begin
        acc_d = acc_q;
        hi_d  = hi_q;
        if (rdValid_q) begin
            if (rdOdd_q) begin
                acc_d = acc_q + {16'h0000, hi_q, iQ};
            end else if (state_q == DRAIN) begin
                acc_d = acc_q + {16'h0000, iQ, 8'h00};
            end else begin
                hi_d = iQ;
            end
        end
    end

    assign fold_d   = {16'h0000, acc_q[15:0]} + {16'h0000, acc_q[31:16]};
    assign idxNext  = idx_q + 16'd1;
    assign addrNext = start_q + idxNext[9:0];

    always_ff @(posedge iDm9000aClk) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            len_q     <= 16'h0000;
            start_q   <= 10'd0;
            idx_q     <= 16'h0000;
            acc_q     <= 32'h0000_0000;
            hi_q      <= 8'h00;
            rdValid_q <= 1'b0;
            rdOdd_q   <= 1'b0;
            addr_q    <= 10'd0;
            chk_q     <= 16'h0000;
            runEnd_q  <= 1'b0;
        end else begin
            rdValid_q <= 1'b0;
            // Dropping the request anywhere but IDLE aborts; this also ends DONE.
            if (state_q != IDLE && !iRunStart) begin
                state_q  <= IDLE;
                addr_q   <= 10'd0;
                runEnd_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (iRunStart && !runEnd_q) begin
                            state_q <= LATCH;
                        end
                    end
                    LATCH: begin
                        len_q   <= in_len;
                        start_q <= in_start_addr;
                        acc_q   <= 32'h0000_0000;
                        idx_q   <= 16'h0000;
                        hi_q    <= 8'h00;
                        if (in_len == 16'h0000) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= READ;
                            addr_q  <= in_start_addr;
                        end
                    end
                    READ: begin
                        rdValid_q <= 1'b1;
                        rdOdd_q   <= idx_q[0];
                        acc_q     <= acc_d;
                        hi_q      <= hi_d;
                        idx_q     <= idxNext;
                        if (idx_q == len_q - 16'd1) begin
                            state_q <= DRAIN;
                            addr_q  <= 10'd0;
                        end else begin
                            addr_q  <= addrNext;
                        end
                    end
                    DRAIN: begin
                        acc_q   <= acc_d;
                        hi_q    <= hi_d;
                        state_q <= FOLD1;
                    end
                    FOLD1: begin
                        acc_q   <= fold_d;
                        state_q <= FOLD2;
                    end
                    FOLD2: begin
                        acc_q    <= fold_d;
                        chk_q    <= fold_d[15:0];
                        runEnd_q <= 1'b1;
                        state_q  <= DONE;
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q  <= IDLE;
                        addr_q   <= 10'd0;
                        runEnd_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oAddress  = addr_q;
    assign oChecksum = chk_q;
    assign oRunEnd   = runEnd_q;

endmodule
